// File: rtl/sensor_ctrl_mc_if.sv
// sensor_ctrl_mc_if: CPU-side control/read bus plus sensor pins for sensor_ctrl_mc.
// Optional macro SCTRL_DROP_CNT_EN adds the sctrl_drop_cnt status word.
interface sensor_ctrl_mc_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned CH_W   = 3
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic                     sctrl_en;
    logic                     sctrl_clear;
    logic [AW-1:0]            sctrl_addr;
    logic [DATA_W-1:0]        sctrl_out;
    logic [CH_W-1:0]          sctrl_ch;
    logic [AW:0]              sctrl_level;
    logic                     sctrl_interrupt;
    logic                     sctrl_err;
    logic [NUM_CH-1:0]        sensor_en;
    logic [NUM_CH-1:0]        sensor_ready;
    logic [NUM_CH*DATA_W-1:0] sensor_out;
`ifdef SCTRL_DROP_CNT_EN
    logic [15:0]              sctrl_drop_cnt;

    modport master (
        output sctrl_en, sctrl_clear, sctrl_addr, sensor_ready, sensor_out,
        input  sctrl_out, sctrl_ch, sctrl_level, sctrl_interrupt, sctrl_err,
               sensor_en, sctrl_drop_cnt
    );
    modport slave (
        input  sctrl_en, sctrl_clear, sctrl_addr, sensor_ready, sensor_out,
        output sctrl_out, sctrl_ch, sctrl_level, sctrl_interrupt, sctrl_err,
               sensor_en, sctrl_drop_cnt
    );
`else
    modport master (
        output sctrl_en, sctrl_clear, sctrl_addr, sensor_ready, sensor_out,
        input  sctrl_out, sctrl_ch, sctrl_level, sctrl_interrupt, sctrl_err,
               sensor_en
    );
    modport slave (
        input  sctrl_en, sctrl_clear, sctrl_addr, sensor_ready, sensor_out,
        output sctrl_out, sctrl_ch, sctrl_level, sctrl_interrupt, sctrl_err,
               sensor_en
    );
`endif
endinterface

// File: rtl/sensor_ctrl_mc.sv
// sensor_ctrl_mc: multi-channel sensor capture into a DEPTH-entry buffer with
// round-robin arbitration, buffer-full interrupt and registered CPU read port.
// Optional macro SCTRL_DROP_CNT_EN: keeps sensors enabled while FULL and counts
// dropped samples (FULL-state pulses and FILL-state overruns) in sctrl_drop_cnt.
module sensor_ctrl_mc #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned CH_W   = 3
) (
    input logic             clk,
    input logic             rst,
    sensor_ctrl_mc_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned RW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_FULL = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [AW-1:0]     wptr;
    logic [AW:0]       level;
    logic [RW-1:0]     rr_ptr;
    logic [NUM_CH-1:0] pending;
    logic              irq;
    logic              err;
    logic [NUM_CH-1:0] sen;
    logic              sen_nxt;

    logic [DATA_W-1:0] hold     [NUM_CH];
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [CH_W-1:0]   mem_tag  [DEPTH];
    logic [DATA_W-1:0] rd_data;
    logic [CH_W-1:0]   rd_tag;

    logic              gnt_valid;
    logic [RW-1:0]     gnt_idx;
    logic [RW-1:0]     cand;
    logic [NUM_CH-1:0] gnt_oh;
    logic              capture;
    logic              do_write;
    logic              full_hit;
    logic [NUM_CH-1:0] take;
    logic [NUM_CH-1:0] ovr;

    assign capture  = (state == ST_FILL) && !bus.sctrl_clear;
    assign do_write = capture && gnt_valid;
    assign full_hit = do_write && (level == (AW+1)'(DEPTH - 1));

    // Round-robin grant: first pending channel at or after rr_ptr
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        gnt_oh    = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            cand = RW'((32'(rr_ptr) + i) % NUM_CH);
            if (!gnt_valid && pending[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
        if (do_write) begin
            gnt_oh[gnt_idx] = 1'b1;
        end
    end

    // Sample acceptance; a channel granted this cycle frees its slot for a new sample
    always_comb begin
        take = '0;
        ovr  = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (capture && bus.sensor_ready[k]) begin
                if (pending[k] && !gnt_oh[k]) begin
                    ovr[k] = 1'b1;
                end else begin
                    take[k] = 1'b1;
                end
            end
        end
    end

    // Next-state: clear restarts the frame from any state
    always_comb begin
        state_nxt = state;
        if (bus.sctrl_clear) begin
            state_nxt = bus.sctrl_en ? ST_FILL : ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (bus.sctrl_en) state_nxt = ST_FILL;
                ST_FILL: begin
                    if (full_hit) begin
                        state_nxt = ST_FULL;
                    end else if (!bus.sctrl_en) begin
                        state_nxt = ST_IDLE;
                    end
                end
                ST_FULL: state_nxt = ST_FULL;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

`ifdef SCTRL_DROP_CNT_EN
    assign sen_nxt = (state_nxt == ST_FILL) || (state_nxt == ST_FULL);
`else
    assign sen_nxt = (state_nxt == ST_FILL);
`endif

    // Control state, pointers, pending flags and status flags
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_IDLE;
            wptr    <= '0;
            level   <= '0;
            rr_ptr  <= '0;
            pending <= '0;
            irq     <= 1'b0;
            err     <= 1'b0;
            sen     <= '0;
        end else begin
            state <= state_nxt;
            sen   <= {NUM_CH{sen_nxt}};
            if (bus.sctrl_clear) begin
                wptr    <= '0;
                level   <= '0;
                pending <= '0;
                irq     <= 1'b0;
                err     <= 1'b0;
            end else begin
                if (do_write) begin
                    wptr   <= wptr + 1'b1;
                    level  <= level + 1'b1;
                    rr_ptr <= RW'((32'(gnt_idx) + 1) % NUM_CH);
                    if (full_hit) begin
                        irq <= 1'b1;
                    end
                end
                if (|ovr) begin
                    err <= 1'b1;
                end
                pending <= (pending & ~gnt_oh) | take;
            end
        end
    end

    // Per-channel holding registers (not reset)
    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (take[k]) begin
                hold[k] <= bus.sensor_out[k*DATA_W +: DATA_W];
            end
        end
    end

    // Buffer RAM write (not reset)
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem_data[wptr] <= hold[gnt_idx];
            mem_tag[wptr]  <= CH_W'(gnt_idx);
        end
    end

    // Registered read port; same-address write in this cycle returns old data
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_data <= '0;
            rd_tag  <= '0;
        end else begin
            rd_data <= mem_data[bus.sctrl_addr];
            rd_tag  <= mem_tag[bus.sctrl_addr];
        end
    end

`ifdef SCTRL_DROP_CNT_EN
    logic [15:0] drop_cnt;
    logic [4:0]  drop_inc;
    logic [16:0] drop_sum;

    // Count drops this cycle: any pulse while FULL plus FILL overruns
    always_comb begin
        drop_inc = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (((state == ST_FULL) && bus.sensor_ready[k]) || ovr[k]) begin
                drop_inc = drop_inc + 5'd1;
            end
        end
        drop_sum = {1'b0, drop_cnt} + 17'(drop_inc);
    end

    // Saturating drop counter
    always_ff @(posedge clk) begin
        if (!rst || bus.sctrl_clear) begin
            drop_cnt <= '0;
        end else if (drop_sum[16]) begin
            drop_cnt <= '1;
        end else begin
            drop_cnt <= drop_sum[15:0];
        end
    end

    assign bus.sctrl_drop_cnt = drop_cnt;
`endif

    assign bus.sctrl_out       = rd_data;
    assign bus.sctrl_ch        = rd_tag;
    assign bus.sctrl_level     = level;
    assign bus.sctrl_interrupt = irq;
    assign bus.sctrl_err       = err;
    assign bus.sensor_en       = sen;
endmodule

// File: doc/sensor_ctrl_mc.md
Name: sensor_ctrl_mc

Overview:
- Multi-channel sensor capture controller; successor to the single-channel sensor stimulus/capture path used by the ISR program.
- Collects samples from NUM_CH sensors into a DEPTH-entry buffer and raises an interrupt to the CPU when the buffer is full.
- The CPU reads the buffer through a registered read port, then pulses clear to start a new frame.
- Sits between the sensor pins and the CPU MMIO/interrupt logic inside top.

Parameters:
- DATA_W, 32, sample width
- DEPTH, 64, buffer entries (power of two, ≥4)
- NUM_CH, 2, sensor channels (1..8)
- CH_W, 3, channel tag width (≥ clog2(NUM_CH), min 1)

Ports:
- clk  in  1  clock
- rst  in  1  reset
- sctrl_en  in  1  capture enable from CPU
- sctrl_clear  in  1  one-cycle pulse: restart frame
- sctrl_addr  in  clog2(DEPTH)  buffer read address
- sctrl_out  out  DATA_W  read data
- sctrl_ch  out  CH_W  channel tag of read entry
- sctrl_level  out  clog2(DEPTH)+1  entries written this frame
- sctrl_interrupt  out  1  buffer-full interrupt, level
- sctrl_err  out  1  sticky channel-overrun flag
- sensor_en  out  NUM_CH  per-channel request
- sensor_ready  in  NUM_CH  per-channel sample strobe
- sensor_out  in  NUM_CH*DATA_W  per-channel data; channel k at [k*DATA_W +: DATA_W]

Behaviour:
- Clock, reset and polarity: one clock, clk. Reset rst is synchronous and active-low.
- Reset values: all outputs 0; state IDLE; write pointer 0; round-robin pointer 0; all pending flags 0.
- Buffer RAM and holding registers are not reset.
- States:
  - IDLE: sctrl_en=1 → FILL.
  - FILL: level reaches DEPTH → FULL; sctrl_en=0 → IDLE, keeping pointer and level.
  - FULL: sctrl_clear → IDLE if sctrl_en=0, else FILL.
  - sctrl_clear in any state: write pointer 0, level 0, interrupt 0, err 0, pending flags 0. Clear has priority over a same-cycle capture; that sample is discarded.
- sensor_en[k] = 1 only in FILL (registered, asserted the cycle after the FILL transition).
- Capture:
  - In FILL, a sensor_ready[k] sample latches sensor_out[k] into holding register k and sets pending[k].
  - If pending[k] is already set, the new sample is dropped and sctrl_err is set (sticky).
- Arbitration:
  - Each FILL cycle, at most one pending channel is written to the buffer.
  - Grant is round-robin: search starts at rr_ptr; after a grant to k, rr_ptr = (k+1) mod NUM_CH.
  - A channel may have ready and grant in the same cycle: the old pending data is written and the new data latched, with no overrun.
- Write: buffer[wptr] = data, tag = k; wptr wraps at DEPTH; level increments.
- Full: level==DEPTH sets sctrl_interrupt on the same edge and enters FULL. No further writes; pending data is retained until clear.
- Read: sctrl_out and sctrl_ch registered, 1-cycle latency from sctrl_addr, available in every state. Read-during-write to the same address returns old data.
- Leaving FILL (sctrl_en=0) freezes capture: sensor_ready is ignored and pending data is held.
- Reset mid-frame behaves as a full clear.

Optional Feature:
- Macro: SCTRL_DROP_CNT_EN.
- Defined:
  - Extra output sctrl_drop_cnt, 16 bits, reset 0, cleared by sctrl_clear.
  - In FULL, sensor_en stays asserted; every sensor_ready pulse while FULL increments sctrl_drop_cnt, saturating at 16'hFFFF.
  - Overruns in FILL also increment it.
- Undefined: port absent; sensor_en deasserts in FULL; ready pulses in FULL are ignored.

Test Plan:
- Reset: rst=0 for 2 cycles with random inputs → all outputs 0, sensor_en=0, level=0.
- Single channel: NUM_CH=1, DEPTH=4, en=1, samples 0xA0..0xA3 on ready pulses 3 cycles apart → interrupt on the edge after the 4th write. Read addr 0..3 → 0xA0..0xA3, tag 0; sensor_en=0.
- Round-robin: NUM_CH=2, both channels ready together every 4 cycles (ch0 0x100+i, ch1 0x200+i) → buffer alternates ch0, ch1, ch0, ch1 with correct tags; err=0.
- Overrun: ch0 ready on 2 consecutive cycles while ch1 wins the grant → err=1. Second ch0 sample dropped and absent from buffer; first ch0 sample present.
- Clear with capture: clear pulse coincident with a ready when level=63 → level=0, interrupt=0, no write. The next sample lands at address 0.
- Drop counter (SCTRL_DROP_CNT_EN): fill DEPTH=4, then 5 ready pulses → sctrl_drop_cnt=5 and sensor_en stays 1. After clear → count 0.
